// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush, data-memory wait
//
// Purpose: derives the per-stage stall/bubble/flush controls of a 5-stage pipeline
// from decode/EX register usage, EX redirects and the MEM-stage data-memory handshake.
// Keeps a stall-cycle counter and a sticky memory-wait watchdog flag.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dRs1/dRs1Used, dRs2/dRs2Used  decode-stage source registers and their use flags
//   exDst/exWrtEn/exIsLoad     EX-stage destination, write enable, load marker
//   exRedirect                 EX-resolved branch/jump changes the PC
//   memReq/memAck              MEM-stage access pending / completing this cycle
//   stallF/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM
//   bubbleE/bubbleW/flushD     NOP into ID/EX, MEM/WB, IF/ID
//   state                      current FSM state (RUN=0, LDSTALL=1, MEMWAIT=2)
//   memTimeout                 sticky watchdog error
//   stallCycles                saturating count of cycles with stallF=1
module hazard_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int LOAD_LAT            = 1,
  parameter int MEM_TIMEOUT         = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dRs1,
  input  logic                           dRs1Used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dRs2,
  input  logic                           dRs2Used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] exDst,
  input  logic                           exWrtEn,
  input  logic                           exIsLoad,
  input  logic                           exRedirect,
  input  logic                           memReq,
  input  logic                           memAck,
  output logic                           stallF,
  output logic                           stallD,
  output logic                           stallE,
  output logic                           stallM,
  output logic                           bubbleE,
  output logic                           bubbleW,
  output logic                           flushD,
  output logic [1:0]                     state,
  output logic                           memTimeout,
  output logic [31:0]                    stallCycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    UNUSED  = 2'd3
  } state_e;

  localparam logic [3:0] LD_INIT     = 4'(LOAD_LAT - 1);
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        resume_ld_q, resume_ld_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic mem_busy;

  assign load_use = exIsLoad & exWrtEn &
                    ((dRs1Used & (dRs1 == exDst)) | (dRs2Used & (dRs2 == exDst)));
  assign mem_busy = memReq & ~memAck;

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    bubbleE     = 1'b0;
    bubbleW     = 1'b0;
    flushD      = 1'b0;
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    resume_ld_d = resume_ld_q;

    if (!reset) begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            {stallF, stallD, stallE, stallM, bubbleW} = 5'b11111;
            state_d     = MEMWAIT;
            resume_ld_d = 1'b0;
          end else if (exRedirect) begin
            flushD  = 1'b1;
            bubbleE = 1'b1;
          end else if (load_use) begin
            {stallF, stallD, bubbleE} = 3'b111;
            if (LOAD_LAT > 1) begin
              state_d  = LDSTALL;
              ld_cnt_d = LD_INIT;
            end
          end
        end

        LDSTALL: begin
          if (mem_busy) begin
            // ld_cnt is left untouched so the remaining stall resumes after the ack
            {stallF, stallD, stallE, stallM, bubbleW} = 5'b11111;
            state_d     = MEMWAIT;
            resume_ld_d = 1'b1;
          end else if (exRedirect) begin
            flushD   = 1'b1;
            bubbleE  = 1'b1;
            ld_cnt_d = 4'd0;
            state_d  = RUN;
          end else begin
            {stallF, stallD, bubbleE} = 3'b111;
            ld_cnt_d = ld_cnt_q - 4'd1;
            if (ld_cnt_q == 4'd1) begin
              state_d = RUN;
            end
          end
        end

        MEMWAIT: begin
          if (mem_busy) begin
            {stallF, stallD, stallE, stallM, bubbleW} = 5'b11111;
          end else begin
            // Exit cycle: a redirect kills any paused load stall; otherwise a paused
            // stall takes precedence over a fresh load-use check.
            resume_ld_d = 1'b0;
            state_d     = RUN;
            if (exRedirect) begin
              flushD   = 1'b1;
              bubbleE  = 1'b1;
              ld_cnt_d = 4'd0;
            end else if (resume_ld_q && (ld_cnt_q != 4'd0)) begin
              state_d = LDSTALL;
            end else if (load_use) begin
              {stallF, stallD, bubbleE} = 3'b111;
              if (LOAD_LAT > 1) begin
                state_d  = LDSTALL;
                ld_cnt_d = LD_INIT;
              end
            end
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (state_q == MEMWAIT) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
    mem_timeout_d  = mem_timeout_q | ((state_q == MEMWAIT) && (wait_cnt_d >= TIMEOUT_LIM));
    stall_cycles_d = stall_cycles_q;
    if (stallF && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      ld_cnt_q       <= 4'd0;
      wait_cnt_q     <= 8'd0;
      resume_ld_q    <= 1'b0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      resume_ld_q    <= resume_ld_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state       = state_q;
  assign memTimeout  = mem_timeout_q;
  assign stallCycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a parameter REG_INDEX_BIT_WIDTH, default 4, giving the register-number width.
REQ-002 The block SHALL have a parameter LOAD_LAT, default 1 (legal 1-15), giving the load-use stall length in cycles.
REQ-003 The block SHALL have a parameter MEM_TIMEOUT, default 255 (legal 1-255), giving the data-memory wait watchdog limit in cycles.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- dRs1  in  REG_INDEX_BIT_WIDTH  decode-stage source register 1
- dRs1Used  in  1  decode instruction reads dRs1
- dRs2  in  REG_INDEX_BIT_WIDTH  decode-stage source register 2
- dRs2Used  in  1  decode instruction reads dRs2
- exDst  in  REG_INDEX_BIT_WIDTH  EX-stage destination register
- exWrtEn  in  1  EX instruction writes exDst
- exIsLoad  in  1  EX instruction is a load
- exRedirect  in  1  branch/jump resolved in EX changes PC
- memReq  in  1  MEM-stage data-memory access pending
- memAck  in  1  data memory completes access this cycle
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID register
- stallE  out  1  hold ID/EX register
- stallM  out  1  hold EX/MEM register
- bubbleE  out  1  load NOP into ID/EX
- bubbleW  out  1  load NOP into MEM/WB
- flushD  out  1  load NOP into IF/ID
- state  out  2  current FSM state
- memTimeout  out  1  sticky watchdog error
- stallCycles  out  32  saturating count of cycles with stallF=1

Function
REQ-005 States SHALL be RUN=0, LDSTALL=1, MEMWAIT=2, with 3 unused (decodes to RUN next cycle, all control outputs 0).
REQ-006 loadUse SHALL be exIsLoad & exWrtEn & ((dRs1Used & dRs1==exDst) | (dRs2Used & dRs2==exDst)); register 0 gets no special treatment.
REQ-007 memBusy SHALL be memReq & ~memAck.
REQ-008 Control outputs SHALL be combinational from state and inputs; state, counters and flags are registered.
REQ-009 Priority in every state: memBusy > exRedirect > load-use/LDSTALL hold.
REQ-010 memBusy in any state: stallF=stallD=stallE=stallM=1, bubbleW=1, other controls 0; next state MEMWAIT.
REQ-011 RUN, not memBusy, exRedirect: flushD=1, bubbleE=1, no stalls; next RUN.
REQ-012 RUN, no memBusy or redirect, loadUse: stallF=stallD=1, bubbleE=1; if LOAD_LAT=1 next RUN, else next LDSTALL with ldCnt=LOAD_LAT-1.
REQ-013 LDSTALL, no memBusy or redirect: stallF=stallD=1, bubbleE=1, ldCnt decrements; exit to RUN on the cycle ldCnt==1, regardless of loadUse.
REQ-014 LDSTALL, exRedirect: same outputs as REQ-011; ldCnt cleared; next RUN.
REQ-015 Entering MEMWAIT from LDSTALL SHALL set resumeLd and freeze ldCnt.
REQ-016 MEMWAIT with memAck=1: no stalls; next state LDSTALL if resumeLd and ldCnt!=0, else RUN; resumeLd cleared. The MEMWAIT-exit cycle evaluates redirect/loadUse per RUN rules.
REQ-017 waitCnt SHALL count consecutive MEMWAIT cycles; when it reaches MEM_TIMEOUT, memTimeout SHALL set and stay set until reset; the state remains MEMWAIT until memAck.
REQ-018 stallCycles SHALL increment on each cycle with stallF=1, saturating at 0xFFFFFFFF.
REQ-019 No other combination asserts any control output.

Reset
REQ-020 When reset=1 at a rising edge: state=RUN, ldCnt=0, waitCnt=0, resumeLd=0, memTimeout=0, stallCycles=0.
REQ-021 While reset=1, all control outputs SHALL be 0 combinationally; reset in any state (including mid-MEMWAIT) aborts with no pending resume.

Verification
REQ-022 LOAD_LAT=1, exIsLoad=exWrtEn=1, exDst=3, dRs2=3, dRs2Used=1 -> one cycle stallF=stallD=bubbleE=1, state stays RUN, stallCycles=1.
REQ-023 LOAD_LAT=3, same hazard then inputs cleared -> stall outputs high for exactly 3 cycles, state 0,1,1,0.
REQ-024 Load-use and exRedirect in the same cycle -> flushD=bubbleE=1, stallF=0, no LDSTALL entry.
REQ-025 memReq=1, memAck=0 for 4 cycles then memAck=1 -> stallF/D/E/M=bubbleW=1 for those 4 cycles, 0 on the ack cycle, state back to RUN.
REQ-026 MEM_TIMEOUT=5, memReq=1, memAck=0 held 10 cycles -> memTimeout rises after the 5th MEMWAIT cycle, stays 1 after ack until reset.
REQ-027 LOAD_LAT=3, memBusy in the 2nd LDSTALL cycle for 2 cycles -> after ack, LDSTALL resumes for the remaining cycle; reset asserted mid-MEMWAIT -> all outputs 0, state RUN.
